edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-input level-to-tick detector.
- Each channel synchronises an asynchronous level input (button/coin sensor), debounces it, and emits one-cycle rise, fall and enabled-edge ticks.
- Sits between raw board inputs and the control FSMs; replaces per-input detector instances.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2).
- DEBOUNCE, 4, consecutive cycles a synchronised value must differ from the debounced value before the debounced value changes (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronous to clk by the system).
- level  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- rise_en  in  CHANNELS  per-channel enable for rising edges on tick.
- fall_en  in  CHANNELS  per-channel enable for falling edges on tick.
- stable  out  CHANNELS  debounced level.
- rise_tick  out  CHANNELS  one-cycle pulse when stable goes 0->1 (unmasked).
- fall_tick  out  CHANNELS  one-cycle pulse when stable goes 1->0 (unmasked).
- tick  out  CHANNELS  (rise_tick & rise_en_q) | (fall_tick & fall_en_q), registered.
- any_tick  out  1  OR of all tick bits, combinational from registered tick.

Behaviour:
- Reset (rst=0):
  - All synchroniser flops, debounce counters, stable, rise_tick, fall_tick and tick go to 0 asynchronously.
  - Any in-progress debounce is discarded.
- Synchroniser: sync_i is level[i] delayed through SYNC_STAGES flops. No logic between the stages.
- Debounce, per channel, evaluated every clk edge:
  - sync_i == stable_i: counter <= 0.
  - sync_i != stable_i and counter < DEBOUNCE-1: counter <= counter+1.
  - sync_i != stable_i and counter == DEBOUNCE-1: stable_i <= sync_i, counter <= 0.
  - Counter width is clog2(DEBOUNCE), minimum 1. The counter never wraps.
- Glitches: a sync_i excursion lasting fewer than DEBOUNCE cycles leaves stable unchanged, produces no tick, and resets the counter on return.
- Ticks:
  - rise_tick_i / fall_tick_i are registered and set on the same edge that stable_i changes. They are high for exactly one cycle.
  - They are never both high on one channel. There are no back-to-back ticks closer than DEBOUNCE cycles.
- tick_i is registered on that same edge, using rise_en/fall_en sampled at that edge.
  - Enables gate only tick. Changing an enable never creates or truncates a pulse.
- Latency: with level held constant from before edge 1, stable and the tick outputs change after edge SYNC_STAGES+DEBOUNCE (edge 6 at defaults).
- Reset release with level already high: after the latency above, stable rises and one rise_tick is produced. This is deliberate; consumers mask it via rise_en if unwanted.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous ticks.
- Mid-operation reset: outputs clear in the same cycle as rst falls. Debounce restarts from 0 after release.

Decomposition:
- Package edge_pkg holds:
  - clog2-based counter width function.
  - Default parameter constants: DEF_SYNC_STAGES=2, DEF_DEBOUNCE=4.
- One sub-module, edge_channel: a single channel's synchroniser, debounce counter, stable, rise/fall/tick registers.
- Top level generates CHANNELS instances and forms any_tick.

Test Plan:
- Reset: assert rst=0 with level=4'hF mid-run -> all outputs 0 same cycle. Release -> stable=4'hF and rise_tick=4'hF exactly one cycle, after edge 6.
- Clean press on ch0: level[0] 0->1 held 20 cycles, rise_en=4'h1 -> rise_tick[0] and tick[0] high one cycle at edge 6; stable[0]=1 thereafter; no fall_tick.
- Glitch rejection: level[1] high for 3 cycles then low -> stable[1] stays 0, no ticks. A 4-cycle pulse produces exactly one rise_tick then one fall_tick 4 cycles later.
- Bounce: level[2] toggles 1,0,1,0,1 each cycle then holds 1 -> exactly one rise_tick[2], 6 edges after the final 0->1.
- Mode masking: fall_en=4'h8, rise_en=0, ch3 press and release -> rise_tick[3] and fall_tick[3] each pulse once; tick[3]/any_tick pulse only on release.
- Simultaneous: all four channels rise on the same cycle with rise_en=4'hF -> tick=4'hF for one cycle, any_tick=1 that cycle only.

Source files
------------

// File: rtl/edge_pkg.sv
// edge_pkg
// Shared constants and helpers for the multi-channel edge detector.
//   DEF_SYNC_STAGES : default synchroniser depth per channel
//   DEF_DEBOUNCE    : default debounce length in clock cycles
//   cnt_width()     : debounce counter width, clog2(depth) with a floor of 1
package edge_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 4;

  // The counter only has to reach depth-1, so clog2(depth) bits suffice.
  // Depths of 1 or 2 still need one physical bit.
  function automatic int cnt_width(input int depth);
    if (depth <= 2) return 1;
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// edge_channel
// One input channel: synchroniser chain, debounce counter, debounced level,
// and registered rise/fall/enabled-edge ticks.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   level     in   raw asynchronous input
//   rise_en   in   enable rising edges onto tick
//   fall_en   in   enable falling edges onto tick
//   stable    out  debounced level
//   rise_tick out  one-cycle pulse when stable goes 0->1
//   fall_tick out  one-cycle pulse when stable goes 1->0
//   tick      out  rise/fall pulse gated by the enables sampled on that edge
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic rise_en,
  input  logic fall_en,
  output logic stable,
  output logic rise_tick,
  output logic fall_tick,
  output logic tick
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_tick;

  logic w_sync;
  logic w_differ;
  logic w_commit;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync ^ r_stable;
  // The debounced value flips on the DEBOUNCE-th consecutive differing cycle.
  assign w_commit = w_differ && (r_cnt == CNT_MAX);

  // Plain flop chain: no logic between stages so metastability can settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], level};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (!w_differ || w_commit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_commit) begin
        r_stable <= w_sync;
      end
      // Ticks are computed from the same commit condition, so they land on
      // the edge stable changes and last exactly one cycle. Enables only
      // gate tick; rise_tick/fall_tick are never masked.
      r_rise <= w_commit & w_sync;
      r_fall <= w_commit & ~w_sync;
      r_tick <= (w_commit & w_sync & rise_en) | (w_commit & ~w_sync & fall_en);
    end
  end

  assign stable    = r_stable;
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;
  assign tick      = r_tick;

endmodule

// File: rtl/edge_detect_multi.sv
// edge_detect_multi
// Multi-channel synchronise/debounce/edge-tick block between raw board
// inputs and the control FSMs.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   level     in   [CHANNELS] raw asynchronous inputs
//   rise_en   in   [CHANNELS] per-channel rising-edge enable for tick
//   fall_en   in   [CHANNELS] per-channel falling-edge enable for tick
//   stable    out  [CHANNELS] debounced levels
//   rise_tick out  [CHANNELS] unmasked rising-edge pulses
//   fall_tick out  [CHANNELS] unmasked falling-edge pulses
//   tick      out  [CHANNELS] enabled-edge pulses (registered)
//   any_tick  out  OR of all tick bits
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] level,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] rise_tick,
  output logic [CHANNELS-1:0] fall_tick,
  output logic [CHANNELS-1:0] tick,
  output logic                any_tick
);

  logic [CHANNELS-1:0] w_tick;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .level     (level[g]),
      .rise_en   (rise_en[g]),
      .fall_en   (fall_en[g]),
      .stable    (stable[g]),
      .rise_tick (rise_tick[g]),
      .fall_tick (fall_tick[g]),
      .tick      (w_tick[g])
    );
  end

  assign tick     = w_tick;
  // Combinational OR of registered ticks: no extra cycle of latency.
  assign any_tick = |w_tick;

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

  logic       clk;
  logic       rst;
  logic [3:0] level;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] stable;
  logic [3:0] rise_tick;
  logic [3:0] fall_tick;
  logic [3:0] tick;
  logic       any_tick;

  int n_tests;
  int n_fail;

  edge_detect_multi #(
    .CHANNELS    (4),
    .SYNC_STAGES (2),
    .DEBOUNCE    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .level     (level),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .stable    (stable),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .tick      (tick),
    .any_tick  (any_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    level   = 4'h0;
    rise_en = 4'h0;
    fall_en = 4'h0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    // Power-on state while held in reset.
    rst = 1'b0; level = 4'h0; rise_en = 4'h0; fall_en = 4'h0;
    step();
    n_tests++;
    if ({stable, rise_tick, fall_tick, tick, any_tick} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_init: got %h want 0", {stable, rise_tick, fall_tick, tick, any_tick});
    end
    rst = 1'b1;
    // Drive all channels high until the rise ticks appear, then reset mid-pulse.
    rise_en = 4'hF;
    level   = 4'hF;
    for (int k = 1; k <= 6; k++) step();
    n_tests++;
    if (rise_tick !== 4'hF || tick !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_pre_rise: rise_tick=%h tick=%h want F F", rise_tick, tick);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({stable, rise_tick, fall_tick, tick, any_tick} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_async_clear: got %h want 0", {stable, rise_tick, fall_tick, tick, any_tick});
    end
    step();
    step();
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) begin
        n_tests++;
        if (stable !== 4'h0 || rise_tick !== 4'h0) begin
          n_fail++;
          $display("FAIL reset_rel_early: stable=%h rise=%h want 0 0", stable, rise_tick);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (stable !== 4'hF || rise_tick !== 4'hF || fall_tick !== 4'h0) begin
          n_fail++;
          $display("FAIL reset_rel_rise: stable=%h rise=%h fall=%h want F F 0", stable, rise_tick, fall_tick);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (stable !== 4'hF || rise_tick !== 4'h0) begin
          n_fail++;
          $display("FAIL reset_rel_after: stable=%h rise=%h want F 0", stable, rise_tick);
        end
      end
    end
  endtask

  task automatic test_press();
    int rise_n, rise_at, tick_n, tick_at, fall_n;
    do_reset();
    rise_en = 4'h1;
    rise_n = 0; rise_at = -1; tick_n = 0; tick_at = -1; fall_n = 0;
    level = 4'h1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rise_tick[0]) begin rise_n++; rise_at = k; end
      if (tick[0])      begin tick_n++; tick_at = k; end
      if (fall_tick !== 4'h0) fall_n++;
    end
    n_tests++;
    if (rise_n !== 1 || rise_at !== 6) begin
      n_fail++;
      $display("FAIL press_rise: count=%0d at=%0d want 1 at 6", rise_n, rise_at);
    end
    n_tests++;
    if (tick_n !== 1 || tick_at !== 6) begin
      n_fail++;
      $display("FAIL press_tick: count=%0d at=%0d want 1 at 6", tick_n, tick_at);
    end
    n_tests++;
    if (fall_n !== 0 || stable !== 4'h1) begin
      n_fail++;
      $display("FAIL press_stable: falls=%0d stable=%h want 0 1", fall_n, stable);
    end
  endtask

  task automatic test_glitch();
    int rise_n, fall_n, stab_n, rise_at, fall_at;
    do_reset();
    rise_n = 0; fall_n = 0; stab_n = 0;
    level = 4'h2;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 3) level = 4'h0;
      if (rise_tick[1]) rise_n++;
      if (fall_tick[1]) fall_n++;
      if (stable[1])    stab_n++;
    end
    n_tests++;
    if (rise_n !== 0 || fall_n !== 0 || stab_n !== 0) begin
      n_fail++;
      $display("FAIL glitch_3cyc: rises=%0d falls=%0d stable_cycles=%0d want 0 0 0", rise_n, fall_n, stab_n);
    end
    // A pulse of exactly DEBOUNCE cycles is accepted.
    rise_n = 0; fall_n = 0; rise_at = -1; fall_at = -1;
    level = 4'h2;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 4) level = 4'h0;
      if (rise_tick[1]) begin rise_n++; rise_at = k; end
      if (fall_tick[1]) begin fall_n++; fall_at = k; end
    end
    n_tests++;
    if (rise_n !== 1 || rise_at !== 6) begin
      n_fail++;
      $display("FAIL glitch_4cyc_rise: count=%0d at=%0d want 1 at 6", rise_n, rise_at);
    end
    n_tests++;
    if (fall_n !== 1 || fall_at !== 10) begin
      n_fail++;
      $display("FAIL glitch_4cyc_fall: count=%0d at=%0d want 1 at 10", fall_n, fall_at);
    end
  endtask

  task automatic test_bounce();
    int rise_n, rise_at, fall_n;
    logic [3:0] seq [5];
    seq = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h4};
    do_reset();
    rise_n = 0; rise_at = -1; fall_n = 0;
    level = seq[0];
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k < 5) level = seq[k];
      if (rise_tick[2]) begin rise_n++; rise_at = k; end
      if (fall_tick[2]) fall_n++;
    end
    // Final 0->1 is driven after step 4, so the rise lands 6 edges later.
    n_tests++;
    if (rise_n !== 1 || rise_at !== 10 || fall_n !== 0) begin
      n_fail++;
      $display("FAIL bounce: rises=%0d at=%0d falls=%0d want 1 at 10, 0", rise_n, rise_at, fall_n);
    end
    n_tests++;
    if (stable !== 4'h4) begin
      n_fail++;
      $display("FAIL bounce_stable: stable=%h want 4", stable);
    end
  endtask

  task automatic test_mask();
    int rise_n, fall_n, tick_n, tick_at, any_n, any_at;
    do_reset();
    rise_en = 4'h0;
    fall_en = 4'h8;
    rise_n = 0; fall_n = 0; tick_n = 0; tick_at = -1; any_n = 0; any_at = -1;
    level = 4'h8;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 12) level = 4'h0;
      if (rise_tick[3]) rise_n++;
      if (fall_tick[3]) fall_n++;
      if (tick[3])  begin tick_n++; tick_at = k; end
      if (any_tick) begin any_n++;  any_at = k;  end
    end
    n_tests++;
    if (rise_n !== 1 || fall_n !== 1) begin
      n_fail++;
      $display("FAIL mask_raw: rises=%0d falls=%0d want 1 1", rise_n, fall_n);
    end
    n_tests++;
    if (tick_n !== 1 || tick_at !== 18) begin
      n_fail++;
      $display("FAIL mask_tick: count=%0d at=%0d want 1 at 18", tick_n, tick_at);
    end
    n_tests++;
    if (any_n !== 1 || any_at !== 18) begin
      n_fail++;
      $display("FAIL mask_any: count=%0d at=%0d want 1 at 18", any_n, any_at);
    end
  endtask

  task automatic test_simultaneous();
    int any_n;
    do_reset();
    rise_en = 4'hF;
    any_n = 0;
    level = 4'hF;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (any_tick) any_n++;
      if (k == 5) begin
        n_tests++;
        if (tick !== 4'h0 || any_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL simul_before: tick=%h any=%b want 0 0", tick, any_tick);
        end
      end
      if (k == 6) begin
        n_tests++;
        if (tick !== 4'hF || any_tick !== 1'b1 || rise_tick !== 4'hF) begin
          n_fail++;
          $display("FAIL simul_edge: tick=%h any=%b rise=%h want F 1 F", tick, any_tick, rise_tick);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (tick !== 4'h0 || any_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL simul_after: tick=%h any=%b want 0 0", tick, any_tick);
        end
      end
    end
    n_tests++;
    if (any_n !== 1) begin
      n_fail++;
      $display("FAIL simul_any_count: count=%0d want 1", any_n);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; level = 4'h0; rise_en = 4'h0; fall_en = 4'h0;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_mask();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
